// File: rtl/msrh_pkg.sv
// ============================================================================
// Module : msrh_pkg
// Shared rename/commit types and sizing constants for the msrh core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package msrh_pkg;

  localparam int DISP_SIZE  = 5;
  localparam int FLIST_SIZE = 32;
  // Large enough for 32 architectural IDs plus one free list per lane
  localparam int RNID_W     = 8;

  typedef struct packed {
    logic                                commit;
    logic [DISP_SIZE-1:0]                rnid_valid;
    logic [DISP_SIZE-1:0][RNID_W-1:0]    old_rnid;
    logic [DISP_SIZE-1:0][RNID_W-1:0]    rd_rnid;
    logic [DISP_SIZE-1:0]                dead_id;
    logic                                all_dead;
  } cmt_rnid_upd_t;

endpackage

`default_nettype wire

// File: rtl/msrh_freelist_ptr.sv
// ============================================================================
// Module : msrh_freelist_ptr
// Wrapping pointer register with increment enable; wraps by natural overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module msrh_freelist_ptr #(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] r_ptr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + WIDTH'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/msrh_freelist.sv
// ============================================================================
// Module : msrh_freelist
// Per-lane free list of physical register IDs: rename pops, commit pushes.
// Optional duplicate/range check on push: MSRH_FREELIST_DUP_CHECK_EN
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module msrh_freelist
  import msrh_pkg::*;
#(
  parameter int LANE  = 0,
  parameter int SIZE  = FLIST_SIZE,
  parameter int WIDTH = RNID_W,
  parameter int INIT  = 32 + LANE * SIZE
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  cmt_rnid_upd_t             i_cmt_rnid_upd,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_pop_id,
  output logic                      o_is_empty,
  output logic [$clog2(SIZE):0]     o_count,
  output logic                      o_err
);

  localparam int PTR_W = $clog2(SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(SIZE);

  logic [WIDTH-1:0] r_entry [SIZE];
  logic [CNT_W-1:0] r_count;
  logic             r_err;
  logic [PTR_W-1:0] w_head;
  logic [PTR_W-1:0] w_tail;

  logic             w_push_req;
  logic [WIDTH-1:0] w_push_id;
  logic             w_empty;
  logic             w_full;
  logic             w_pop_eff;
  logic             w_push_legal;
  logic             w_push_eff;
  logic             w_unused;

  assign w_push_req = i_cmt_rnid_upd.commit & i_cmt_rnid_upd.rnid_valid[LANE];
  // A dead instruction never used its new mapping, so that one is recycled
  assign w_push_id  = (i_cmt_rnid_upd.dead_id[LANE] | i_cmt_rnid_upd.all_dead) ?
                      i_cmt_rnid_upd.rd_rnid[LANE] : i_cmt_rnid_upd.old_rnid[LANE];
  assign w_unused   = ^i_cmt_rnid_upd;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_full_cnt);
  assign w_pop_eff  = i_pop & ~w_empty;
  assign w_push_eff = w_push_req & (~w_full | w_pop_eff) & w_push_legal;

`ifdef MSRH_FREELIST_DUP_CHECK_EN
  localparam logic [WIDTH-1:0] c_init = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] c_size = WIDTH'(SIZE);

  logic [SIZE-1:0]  r_present;
  logic [WIDTH-1:0] w_push_off;
  logic [PTR_W-1:0] w_push_idx;
  logic [PTR_W-1:0] w_pop_idx;
  logic             w_in_range;
  logic             w_dup;

  assign w_push_off = w_push_id - c_init;
  assign w_push_idx = PTR_W'(w_push_off);
  assign w_pop_idx  = PTR_W'(r_entry[w_head] - c_init);
  assign w_in_range = (w_push_id >= c_init) && (w_push_off < c_size);
  // The same-cycle pop of this id clears its bit before the push sets it
  assign w_dup      = r_present[w_push_idx] & ~(w_pop_eff && (w_pop_idx == w_push_idx));
  assign w_push_legal = w_in_range & ~w_dup;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_present <= '1;
    end else begin
      if (w_pop_eff) begin
        r_present[w_pop_idx] <= 1'b0;
      end
      if (w_push_eff) begin
        r_present[w_push_idx] <= 1'b1;
      end
    end
  end
`else
  assign w_push_legal = 1'b1;
`endif

  msrh_freelist_ptr #(.WIDTH(PTR_W)) u_head (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (w_pop_eff),
    .o_ptr     (w_head)
  );

  msrh_freelist_ptr #(.WIDTH(PTR_W)) u_tail (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (w_push_eff),
    .o_ptr     (w_tail)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < SIZE; k++) begin
        r_entry[k] <= WIDTH'(INIT + k);
      end
    end else if (w_push_eff) begin
      r_entry[w_tail] <= w_push_id;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= c_full_cnt;
      r_err   <= 1'b0;
    end else begin
      r_count <= r_count + CNT_W'(w_push_eff) - CNT_W'(w_pop_eff);
      if ((i_pop & w_empty) | (w_push_req & ~w_push_eff)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_pop_id   = r_entry[w_head];
  assign o_is_empty = w_empty;
  assign o_count    = r_count;
  assign o_err      = r_err;

endmodule

`default_nettype wire
